// File: rtl/addr_window_map_if.sv
// Bus bundle for addr_window_map: SNES sample side, MCU table-load side and
// translated result side.
interface addr_window_map_if #(
    parameter int NWIN   = 8,
    parameter int ADDR_W = 24,
    parameter int CNT_W  = 16
);
    localparam int WIN_W = (NWIN > 1) ? $clog2(NWIN) : 1;

    logic [ADDR_W-1:0] snes_addr;
    logic              addr_valid;
    logic              snes_busy;
    logic              mcu_wr;
    logic [WIN_W-1:0]  mcu_win;
    logic [2:0]        mcu_field;
    logic [ADDR_W-1:0] mcu_data;
    logic              commit_req;
    logic              commit_ack;
    logic              commit_pend;
    logic              miss_clr;
    logic              out_valid;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_hit;
    logic              is_writable;
    logic              is_saveram;
    logic [CNT_W-1:0]  miss_cnt;

    modport master (
        output snes_addr, addr_valid, snes_busy, mcu_wr, mcu_win, mcu_field,
               mcu_data, commit_req, miss_clr,
        input  commit_ack, commit_pend, out_valid, rom_addr, rom_hit,
               is_writable, is_saveram, miss_cnt
    );

    modport slave (
        input  snes_addr, addr_valid, snes_busy, mcu_wr, mcu_win, mcu_field,
               mcu_data, commit_req, miss_clr,
        output commit_ack, commit_pend, out_valid, rom_addr, rom_hit,
               is_writable, is_saveram, miss_cnt
    );
endinterface

// File: rtl/addr_window_map.sv
// Runtime-programmable SNES address window translator: shadow/active window
// tables with atomic commit, two-stage decode pipeline and saturating miss count.
module addr_window_map #(
    parameter int NWIN   = 8,
    parameter int ADDR_W = 24,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    addr_window_map_if.slave  bus
);
    // state   | meaning
    // IDLE    | no commit outstanding
    // PEND    | commit requested, waiting for idle bus and drained pipeline
    // ACK     | copy done last cycle, ack pulse
    localparam int WIN_W = (NWIN > 1) ? $clog2(NWIN) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_ACK} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] mval;
        logic [ADDR_W-1:0] mmask;
        logic [ADDR_W-1:0] xmask;
        logic [ADDR_W-1:0] target;
        logic [2:0]        flags;
    } win_t;

    state_t            state_q, state_d;
    win_t              shadow_q [NWIN];
    win_t              shadow_d [NWIN];
    win_t              active_q [NWIN];
    win_t              active_d [NWIN];
    logic              s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
    logic [NWIN-1:0]   s1_match_q, s1_match_d;
    logic [WIN_W-1:0]  s1_idx_q, s1_idx_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              rom_hit_q, rom_hit_d;
    logic              is_wr_q, is_wr_d;
    logic              is_sav_q, is_sav_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic              copy;
    logic              s1_hit;
    win_t              sel;

    assign copy = (state_q == ST_PEND) && !bus.snes_busy && !bus.addr_valid
                  && !s1_valid_q && !out_valid_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.commit_req) state_d = ST_PEND;
            ST_PEND: if (copy) state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Copy samples the pre-write shadow, so a same-cycle MCU write is not committed.
    always_comb begin
        shadow_d = shadow_q;
        active_d = copy ? shadow_q : active_q;
        if (bus.mcu_wr && (int'(bus.mcu_win) < NWIN)) begin
            case (bus.mcu_field)
                3'd0: shadow_d[bus.mcu_win].mval   = bus.mcu_data;
                3'd1: shadow_d[bus.mcu_win].mmask  = bus.mcu_data;
                3'd2: shadow_d[bus.mcu_win].xmask  = bus.mcu_data;
                3'd3: shadow_d[bus.mcu_win].target = bus.mcu_data;
                3'd4: shadow_d[bus.mcu_win].flags  = bus.mcu_data[2:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        s1_valid_d = bus.addr_valid;
        s1_addr_d  = s1_addr_q;
        s1_match_d = s1_match_q;
        s1_idx_d   = s1_idx_q;
        if (bus.addr_valid) begin
            s1_addr_d = bus.snes_addr;
            s1_idx_d  = '0;
            for (int i = 0; i < NWIN; i++) begin
                s1_match_d[i] = active_q[i].flags[0] &&
                    ((bus.snes_addr & active_q[i].mmask) ==
                     (active_q[i].mval & active_q[i].mmask));
            end
            for (int i = NWIN - 1; i >= 0; i--) begin
                if (s1_match_d[i]) s1_idx_d = WIN_W'(i);
            end
        end
    end

    // Commit never lands while stage 1 is occupied, so stage 2 can index the active table.
    assign s1_hit = |s1_match_q;
    assign sel    = active_q[s1_idx_q];

    always_comb begin
        out_valid_d = s1_valid_q;
        rom_addr_d  = rom_addr_q;
        rom_hit_d   = rom_hit_q;
        is_wr_d     = is_wr_q;
        is_sav_d    = is_sav_q;
        miss_cnt_d  = miss_cnt_q;
        if (s1_valid_q) begin
            rom_addr_d = s1_hit ? (sel.target + (s1_addr_q & sel.xmask)) : '0;
            rom_hit_d  = s1_hit;
            is_wr_d    = s1_hit && sel.flags[1];
            is_sav_d   = s1_hit && sel.flags[2];
        end
        if (bus.miss_clr) begin
            miss_cnt_d = '0;
        end else if (s1_valid_q && !s1_hit && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shadow_q    <= '{default: '0};
            active_q    <= '{default: '0};
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_match_q  <= '0;
            s1_idx_q    <= '0;
            out_valid_q <= 1'b0;
            rom_addr_q  <= '0;
            rom_hit_q   <= 1'b0;
            is_wr_q     <= 1'b0;
            is_sav_q    <= 1'b0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            s1_valid_q  <= s1_valid_d;
            s1_addr_q   <= s1_addr_d;
            s1_match_q  <= s1_match_d;
            s1_idx_q    <= s1_idx_d;
            out_valid_q <= out_valid_d;
            rom_addr_q  <= rom_addr_d;
            rom_hit_q   <= rom_hit_d;
            is_wr_q     <= is_wr_d;
            is_sav_q    <= is_sav_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign bus.commit_pend = (state_q == ST_PEND);
    assign bus.commit_ack  = (state_q == ST_ACK);
    assign bus.out_valid   = out_valid_q;
    assign bus.rom_addr    = rom_addr_q;
    assign bus.rom_hit     = rom_hit_q;
    assign bus.is_writable = is_wr_q;
    assign bus.is_saveram  = is_sav_q;
    assign bus.miss_cnt    = miss_cnt_q;
endmodule

// File: tb/tb_addr_window_map.sv
// Self-checking bench for addr_window_map: behavioural window model checked every
// cycle, plus directed literal expectations.
module tb_addr_window_map;
    localparam int NWIN = 8;
    localparam int AW   = 24;
    localparam int CW   = 16;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    addr_window_map_if #(.NWIN(NWIN), .ADDR_W(AW), .CNT_W(CW)) bus ();

    addr_window_map #(.NWIN(NWIN), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] mval, mmask, xmask, target;
        logic [2:0]    flags;
    } mwin_t;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] addr;
        logic          hit, wr, sav;
    } res_t;

    mwin_t         m_sh  [NWIN];
    mwin_t         m_act [NWIN];
    res_t          m_s1, m_out;
    logic [CW-1:0] m_miss;
    logic          m_pend, m_ack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t decode_fn(input logic [AW-1:0] a);
        res_t r;
        r = '{valid: 1'b1, addr: '0, hit: 1'b0, wr: 1'b0, sav: 1'b0};
        for (int i = 0; i < NWIN; i++) begin
            if (m_act[i].flags[0] && ((a & m_act[i].mmask) == (m_act[i].mval & m_act[i].mmask))) begin
                r.addr = m_act[i].target + (a & m_act[i].xmask);
                r.hit  = 1'b1;
                r.wr   = m_act[i].flags[1];
                r.sav  = m_act[i].flags[2];
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NWIN; i++) begin
            m_sh[i]  = '{default: '0};
            m_act[i] = '{default: '0};
        end
        m_s1   = '0;
        m_out  = '0;
        m_miss = '0;
        m_pend = 1'b0;
        m_ack  = 1'b0;
    endtask

    initial model_clear();

    always @(posedge clk) begin
        if (!rst_n) begin
            model_clear();
        end else begin
            automatic logic do_copy;
            do_copy = m_pend && !bus.snes_busy && !bus.addr_valid && !m_s1.valid && !m_out.valid;
            if (bus.miss_clr) m_miss = '0;
            else if (m_s1.valid && !m_s1.hit && m_miss != '1) m_miss = m_miss + 1'b1;
            if (m_s1.valid) m_out = m_s1;
            else m_out.valid = 1'b0;
            m_s1 = bus.addr_valid ? decode_fn(bus.snes_addr) : '0;
            if (m_pend) begin
                m_ack  = do_copy;
                m_pend = !do_copy;
            end else begin
                m_pend = !m_ack && bus.commit_req;
                m_ack  = 1'b0;
            end
            if (do_copy) m_act = m_sh;
            if (bus.mcu_wr && int'(bus.mcu_win) < NWIN) begin
                case (bus.mcu_field)
                    3'd0: m_sh[bus.mcu_win].mval   = bus.mcu_data;
                    3'd1: m_sh[bus.mcu_win].mmask  = bus.mcu_data;
                    3'd2: m_sh[bus.mcu_win].xmask  = bus.mcu_data;
                    3'd3: m_sh[bus.mcu_win].target = bus.mcu_data;
                    3'd4: m_sh[bus.mcu_win].flags  = bus.mcu_data[2:0];
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_out_valid", 32'(bus.out_valid),   32'(m_out.valid));
            chk("m_rom_addr",  32'(bus.rom_addr),    32'(m_out.addr));
            chk("m_rom_hit",   32'(bus.rom_hit),     32'(m_out.hit));
            chk("m_writable",  32'(bus.is_writable), 32'(m_out.wr));
            chk("m_saveram",   32'(bus.is_saveram),  32'(m_out.sav));
            chk("m_miss_cnt",  32'(bus.miss_cnt),    32'(m_miss));
            chk("m_pend",      32'(bus.commit_pend), 32'(m_pend));
            chk("m_ack",       32'(bus.commit_ack),  32'(m_ack));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mcu_write(input int win, input int field, input logic [AW-1:0] data);
        bus.mcu_wr    = 1'b1;
        bus.mcu_win   = 3'(win);
        bus.mcu_field = 3'(field);
        bus.mcu_data  = data;
        tick();
        bus.mcu_wr    = 1'b0;
    endtask

    task automatic load_win(input int w, input logic [AW-1:0] mv, input logic [AW-1:0] mm,
                            input logic [AW-1:0] xm, input logic [AW-1:0] tg, input logic [2:0] fl);
        mcu_write(w, 0, mv);
        mcu_write(w, 1, mm);
        mcu_write(w, 2, xm);
        mcu_write(w, 3, tg);
        mcu_write(w, 4, AW'(fl));
    endtask

    task automatic decode(input logic [AW-1:0] a);
        bus.addr_valid = 1'b1;
        bus.snes_addr  = a;
        tick();
        bus.addr_valid = 1'b0;
        tick();
    endtask

    task automatic do_commit(input string name);
        int n;
        bus.commit_req = 1'b1;
        tick();
        bus.commit_req = 1'b0;
        n = 0;
        while (!bus.commit_ack && n < 20) begin
            tick();
            n++;
        end
        chk(name, 32'(bus.commit_ack), 32'd1);
    endtask

    initial begin
        int n;
        bus.snes_addr  = '0;
        bus.addr_valid = 1'b0;
        bus.snes_busy  = 1'b0;
        bus.mcu_wr     = 1'b0;
        bus.mcu_win    = '0;
        bus.mcu_field  = '0;
        bus.mcu_data   = '0;
        bus.commit_req = 1'b0;
        bus.miss_clr   = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid),   32'd0);
        chk("rst_rom_addr",  32'(bus.rom_addr),    32'd0);
        chk("rst_miss",      32'(bus.miss_cnt),    32'd0);
        chk("rst_pend",      32'(bus.commit_pend), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        decode(24'h008000);
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_hit",   32'(bus.rom_hit),   32'd0);
        chk("t1_addr",  32'(bus.rom_addr),  32'd0);
        chk("t1_miss",  32'(bus.miss_cnt),  32'd1);

        load_win(0, 24'h008000, 24'h408000, 24'h3F7FFF, 24'h000000, 3'b001);
        decode(24'h018123);
        chk("t2_precommit_hit", 32'(bus.rom_hit),  32'd0);
        chk("t2_miss",          32'(bus.miss_cnt), 32'd2);
        do_commit("t2_ack");
        decode(24'h018123);
        chk("t2_hit",  32'(bus.rom_hit),  32'd1);
        chk("t2_addr", 32'(bus.rom_addr), 32'h010123);

        load_win(1, 24'h700000, 24'hF00000, 24'h00FFFF, 24'hE00000, 3'b111);
        load_win(3, 24'h700000, 24'hF00000, 24'h00FFFF, 24'h100000, 3'b001);
        do_commit("t3_ack");
        decode(24'h700010);
        chk("t3_addr", 32'(bus.rom_addr),    32'hE00010);
        chk("t3_wr",   32'(bus.is_writable), 32'd1);
        chk("t3_sav",  32'(bus.is_saveram),  32'd1);

        mcu_write(1, 3, 24'hA00000);
        bus.snes_busy  = 1'b1;
        bus.commit_req = 1'b1;
        tick();
        bus.commit_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.addr_valid = 1'b1;
            bus.snes_addr  = 24'h700020 + AW'(i);
            bus.commit_req = (i == 2);
            tick();
            bus.commit_req = 1'b0;
            chk("t4_pend", 32'(bus.commit_pend), 32'd1);
        end
        chk("t4_old_table", 32'(bus.rom_addr), 32'hE00023);
        bus.snes_busy  = 1'b0;
        bus.addr_valid = 1'b0;
        n = 0;
        while (!bus.commit_ack && n < 10) begin
            tick();
            n++;
        end
        chk("t4_drain_cycles", 32'(n), 32'd3);
        chk("t4_pend_clr", 32'(bus.commit_pend), 32'd0);
        tick();
        chk("t4_single_ack", 32'(bus.commit_ack), 32'd0);
        decode(24'h700010);
        chk("t4_new_table", 32'(bus.rom_addr), 32'hA00010);

        load_win(2, 24'h000000, 24'hFF0000, 24'h0000FF, 24'hFFFFF0, 3'b001);
        do_commit("t5_ack");
        decode(24'h000020);
        chk("t5_wrap_hit",  32'(bus.rom_hit),  32'd1);
        chk("t5_wrap_addr", 32'(bus.rom_addr), 32'h000010);

        bus.addr_valid = 1'b1;
        bus.snes_addr  = 24'h800000;
        repeat (65540) tick();
        bus.addr_valid = 1'b0;
        tick();
        tick();
        chk("t6_saturate", 32'(bus.miss_cnt), 32'hFFFF);
        bus.addr_valid = 1'b1;
        tick();
        bus.addr_valid = 1'b0;
        bus.miss_clr   = 1'b1;
        tick();
        bus.miss_clr   = 1'b0;
        chk("t6_clr_miss", 32'(bus.miss_cnt),  32'd0);
        chk("t6_clr_valid", 32'(bus.out_valid), 32'd1);
        decode(24'h800000);
        chk("t6_after_clr", 32'(bus.miss_cnt), 32'd1);

        bus.snes_busy  = 1'b1;
        bus.commit_req = 1'b1;
        tick();
        bus.commit_req = 1'b0;
        bus.addr_valid = 1'b1;
        bus.snes_addr  = 24'h700010;
        tick();
        tick();
        chk("t7_pre_pend",  32'(bus.commit_pend), 32'd1);
        chk("t7_pre_valid", 32'(bus.out_valid),   32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_out_valid", 32'(bus.out_valid),   32'd0);
        chk("t7_rom_addr",  32'(bus.rom_addr),    32'd0);
        chk("t7_hit",       32'(bus.rom_hit),     32'd0);
        chk("t7_wr",        32'(bus.is_writable), 32'd0);
        chk("t7_sav",       32'(bus.is_saveram),  32'd0);
        chk("t7_miss",      32'(bus.miss_cnt),    32'd0);
        chk("t7_pend",      32'(bus.commit_pend), 32'd0);
        chk("t7_ack",       32'(bus.commit_ack),  32'd0);
        bus.addr_valid = 1'b0;
        bus.snes_busy  = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (5) begin
            tick();
            chk("t7_no_ack", 32'(bus.commit_ack), 32'd0);
        end
        decode(24'h018123);
        chk("t7_table_cleared", 32'(bus.rom_hit),  32'd0);
        chk("t7_miss_after",    32'(bus.miss_cnt), 32'd1);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
